// File: rtl/fetch_pkg.sv
// fetch_pkg: shared word width, reset PC, fetch-entry struct and halt FSM states
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  typedef enum logic {RUN, HALT} state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/response bus
interface instr_fetch_unit_if import fetch_pkg::*; ();
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of any depth >= 1 with flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic [31:0],
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T din,
  output T head,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= inc(wr);
      end
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, credit-limited imem requester and prefetch buffer; FETCH_ALIGN_CHECK_EN adds the misaligned-redirect HALT trap
module instr_fetch_unit import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_unit_if.master imem,
  input  logic redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic if_valid,
  input  logic id_ready,
  output logic [XLEN-1:0] INSTRout,
  output logic [XLEN-1:0] PCout,
  output logic [XLEN-1:0] PCnext,
  output logic fetch_fault
);
  localparam int FCW = $clog2(BUF_DEPTH + 1);
  localparam int QCW = $clog2(MAX_OUTSTANDING + 1);
  logic [XLEN-1:0] fpc, pcq_head, load_pc;
  logic [QCW-1:0] out_cnt, discard;
  logic [FCW-1:0] fifo_cnt;
  logic live, halted, gnt_acc, rv_acc, pop, push;
  logic pcq_full, pcq_empty, fifo_full, fifo_empty;
  fetch_entry_t head, entry;
  assign gnt_acc = imem.imem_req && imem.imem_gnt;
  assign rv_acc = imem.imem_rvalid && !pcq_empty;
  assign pop = if_valid && id_ready;
  assign push = rv_acc && discard == '0 && !redirect && !fifo_full;
  assign entry = '{pc: pcq_head, instr: imem.imem_rdata};
  assign imem.imem_addr = fpc;
  // a same-cycle pop frees its slot, so single-cycle memory streams at full rate
  assign imem.imem_req = live && !halted && !pcq_full &&
                         (int'(out_cnt) + int'(fifo_cnt) - int'(pop) < BUF_DEPTH);
  assign if_valid = !fifo_empty;
  assign INSTRout = head.instr;
  assign PCout = head.pc;
  assign PCnext = head.pc + 32'd4;
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .T(logic [XLEN-1:0])) u_pcq (
    .clk(clk), .rst_n(rst_n), .push(gnt_acc), .pop(rv_acc), .flush(1'b0), .din(fpc),
    .head(pcq_head), .count(out_cnt), .full(pcq_full), .empty(pcq_empty)
  );
  fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_buf (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(redirect || halted), .din(entry),
    .head(head), .count(fifo_cnt), .full(fifo_full), .empty(fifo_empty)
  );
`ifdef FETCH_ALIGN_CHECK_EN
  state_t state, state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_n;
  always_comb state_n = redirect ? (redirect_pc[1:0] != 2'b00 ? HALT : RUN) : state;
  assign halted = state == HALT;
  assign fetch_fault = halted;
  assign load_pc = redirect_pc;
`else
  assign halted = 1'b0;
  assign fetch_fault = 1'b0;
  assign load_pc = redirect_pc & ~XLEN'(3);
`endif
  // on redirect every request granted so far, including this cycle's, is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      live <= 1'b0;
      fpc <= RESET_PC;
      discard <= '0;
    end else begin
      live <= 1'b1;
      fpc <= redirect ? load_pc : gnt_acc ? fpc + 32'd4 : fpc;
      discard <= redirect ? out_cnt + QCW'(gnt_acc) - QCW'(rv_acc) :
                 (rv_acc && discard != '0) ? discard - QCW'(1) : discard;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random stimulus against a transaction-level fetch model with an in-order memory
module tb_instr_fetch_unit;
  import fetch_pkg::*;
  localparam int MAXO = 2;
  localparam int BUFD = 2;
  typedef struct {logic [31:0] addr; int due; bit stale;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0, redirect = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_pc = '0, INSTRout, PCout, PCnext;
  logic if_valid, fetch_fault;
  int n_cmp = 0, n_err = 0, cyc = 0, delivered = 0, first_valid = -1;
  req_t pend[$];
  ent_t fbuf[$];
  logic [31:0] exp_addr = '0, exp_pc = '0, hold_pc;
  bit halted = 1'b0;
  instr_fetch_unit_if imem();
  instr_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(BUFD), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .id_ready(id_ready), .INSTRout(INSTRout), .PCout(PCout),
    .PCnext(PCnext), .fetch_fault(fetch_fault)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    #1;
    chk("rst_req", imem.imem_req, 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk("rst_valid", if_valid, 32'h0);
    chk("rst_instr", INSTRout, 32'h0);
    chk("rst_pc", PCout, 32'h0);
    chk("rst_pcnext", PCnext, 32'h4);
    chk("rst_fault", fetch_fault, 32'h0);
    pend.delete();
    fbuf.delete();
    halted = 1'b0;
    exp_addr = '0;
    exp_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic cycle(input bit rdr, input logic [31:0] tgt, input int rdy_pct,
                       input int gnt_pct, input int lat_lo, input int lat_hi);
    bit rv, pop, exp_req, gnt;
    req_t r;
    rv = pend.size() > 0 && pend[0].due <= cyc;
    id_ready = int'($urandom_range(99)) < rdy_pct;
    redirect = rdr;
    redirect_pc = tgt;
    imem.imem_rvalid = rv || (pend.size() == 0 && $urandom_range(7) == 0);
    imem.imem_rdata = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    gnt = imem.imem_req ? int'($urandom_range(99)) < gnt_pct : $urandom_range(3) == 0;
    imem.imem_gnt = gnt;
    #1;
    pop = fbuf.size() > 0 && id_ready;
    exp_req = cyc >= 1 && !halted && pend.size() < MAXO &&
              pend.size() + fbuf.size() - int'(pop) < BUFD;
    chk("imem_req", imem.imem_req, exp_req);
    chk("imem_addr", imem.imem_addr, exp_addr);
    chk("if_valid", if_valid, fbuf.size() > 0);
    chk("fetch_fault", fetch_fault, halted);
    if (fbuf.size() > 0) begin
      chk("PCout", PCout, fbuf[0].pc);
      chk("INSTRout", INSTRout, fbuf[0].instr);
      chk("PCnext", PCnext, fbuf[0].pc + 32'd4);
    end
    if (if_valid && first_valid < 0) first_valid = cyc;
    if (pop) begin
      chk("program_order", PCout, exp_pc);
      exp_pc = exp_pc + 32'd4;
      void'(fbuf.pop_front());
      delivered++;
    end
    if (rv) begin
      r = pend.pop_front();
      if (!r.stale && !rdr) fbuf.push_back('{r.addr, mem_word(r.addr)});
    end
    if (imem.imem_req && gnt) begin
      pend.push_back('{imem.imem_addr, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
      exp_addr = exp_addr + 32'd4;
    end
    if (rdr) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      fbuf.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      halted = tgt[1:0] != 2'b00;
      exp_addr = tgt;
`else
      exp_addr = tgt & ~32'h3;
`endif
      exp_pc = exp_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [31:0] tgt;
    bit rdr;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    #2;
    apply_reset();
    for (int i = 0; i < 10; i++) cycle(0, 0, 100, 100, 1, 1);
    chk("first_valid_cycle", first_valid, 32'd3);
    chk("stream_count", delivered, 32'd7);
    hold_pc = exp_pc;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 100, 1, 1);
    chk("stall_hold_pc", PCout, hold_pc);
    chk("stall_req_low", imem.imem_req, 32'h0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 100, 100, 1, 1);
    for (int i = 0; i < 20 && (pend.size() > 0 || fbuf.size() > 0); i++) cycle(0, 0, 100, 0, 1, 1);
    cycle(1, 32'h10, 100, 0, 1, 1);
    cycle(0, 0, 100, 100, 3, 3);
    cycle(0, 0, 100, 100, 3, 3);
    for (int i = 0; i < 10 && !(pend.size() > 0 && pend[0].due <= cyc); i++) cycle(0, 0, 100, 0, 1, 1);
    cycle(1, 32'h200, 100, 0, 1, 1);
    for (int i = 0; i < 12 && !if_valid; i++) cycle(0, 0, 100, 100, 1, 1);
    chk("redirect_valid", if_valid, 32'h1);
    chk("redirect_first_pc", PCout, 32'h200);
    cycle(1, 32'hFFFF_FFF8, 100, 100, 1, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 100, 100, 1, 1);
    cycle(1, 32'h102, 100, 100, 1, 1);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_fault", fetch_fault, 32'h1);
    chk("misalign_req", imem.imem_req, 32'h0);
`else
    chk("misalign_addr", imem.imem_addr, 32'h100);
    chk("misalign_fault", fetch_fault, 32'h0);
`endif
    for (int i = 0; i < 3; i++) cycle(0, 0, 100, 100, 1, 1);
    cycle(1, 32'h100, 100, 100, 1, 1);
    chk("realign_fault", fetch_fault, 32'h0);
    chk("realign_req", imem.imem_req, 32'h1);
    chk("realign_addr", imem.imem_addr, 32'h100);
    start = delivered;
    for (int i = 0; i < 400; i++) begin
      rdr = $urandom_range(19) == 0;
      tgt = $urandom_range(3) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
      cycle(rdr, tgt, 70, 60, 1, 4);
    end
    chk("random_progress", delivered > start + 20, 32'h1);
    for (int i = 0; i < 20 && !(pend.size() > 0 && fbuf.size() > 0); i++) cycle(0, 0, 0, 100, 4, 6);
    apply_reset();
    cycle(0, 0, 100, 100, 1, 1);
    chk("restart_req", imem.imem_req, 32'h1);
    chk("restart_addr", imem.imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 100, 100, 1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
